vr_rr_arbiter: RTL and testbench
================================

# vr_rr_arbiter

Round-robin arbiter sharing one downstream valid/ready slave port among N upstream requesters. Each requester presents an L-bit word with a valid/ready handshake; the arbiter grants one requester at a time, routes its valid and data to the shared slave, and returns the slave's ready only to the granted requester. It sits directly in front of the team's single-consumer slave datapath so several producers can feed it without contention.

## Interface

- L, default 8, data word width in bits
- N, default 4, number of requesters (2..16)
- MAX_BURST, default 4, maximum beats per grant when burst mode is compiled in (1..16)
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- s_valid  input  N  per-requester valid, bit i belongs to requester i
- s_data  input  N*L  per-requester data, requester i at bits [i*L +: L]
- s_ready  output  N  per-requester ready, at most one bit high
- m_valid  output  1  valid toward the shared slave
- m_data  output  L  data toward the shared slave
- m_ready  input  1  ready from the shared slave
- grant  output  N  registered one-hot grant, all-zero when idle
- busy  output  1  high while in GRANT state

## Operation

- State machine with two states, IDLE and GRANT; registers: state, grant (one-hot), ptr (index, ceil(log2 N) bits), beat_cnt (4 bits).
- IDLE: m_valid=0, s_ready=0, m_data=0. If any s_valid bit is high, select the first set bit scanning ptr, ptr+1, …, N-1, 0, …, ptr-1; load grant with that one-hot, clear beat_cnt, go to GRANT. If no s_valid, stay in IDLE.
- GRANT, granted index g: m_valid = s_valid[g], m_data = s_data[g], s_ready[g] = m_ready, all other s_ready bits 0. These paths are combinational from registered grant.
- Beat = cycle in GRANT with s_valid[g] && m_ready. On each beat, beat_cnt increments.
- Release (GRANT -> IDLE, grant cleared, ptr <= (g+1) mod N) when either:
  - a beat occurs and it is the last beat of the grant (see Configuration), or
  - s_valid[g] is low (requester withdrew); no beat occurs in that cycle.
- Non-granted requesters see s_ready=0 regardless of m_ready; their s_valid is ignored until the next IDLE cycle.
- Requesters must hold s_valid and s_data stable until their beat; the arbiter does not buffer data.

## Timing

- Reset (rst low, asynchronous): state=IDLE, grant=0, ptr=0, beat_cnt=0; hence m_valid=0, m_data=0, s_ready=0, busy=0 immediately.
- Arbitration latency: s_valid rising in IDLE at edge k -> grant and busy high after edge k+1; first beat possible in cycle after edge k+1.
- Each grant costs one IDLE cycle; with burst off, peak throughput is one beat per two cycles.
- Release is registered: after the releasing edge, the arbiter is in IDLE for exactly one cycle before any new grant.
- Simultaneous requests in IDLE: resolved purely by ptr order; the previously granted requester has lowest priority.
- ptr wraps from N-1 to 0.
- Reset asserted mid-burst: grant drops immediately; any word presented but not accepted by m_ready is not transferred.
- m_ready high while m_valid low has no effect.

## Configuration

- ARB_BURST_EN defined: a beat is the last beat when beat_cnt == MAX_BURST-1 (i.e. up to MAX_BURST consecutive beats per grant). The grant also ends early if s_valid[g] drops.
- ARB_BURST_EN undefined: every beat is the last beat; MAX_BURST and beat_cnt are unused (beat_cnt stays 0).

## Test plan

- Reset: hold rst low with s_valid=4'b1111, m_ready=1 -> s_ready=0, m_valid=0, grant=0, busy=0 throughout.
- Single requester, burst off: s_valid=4'b0100, s_data[2]=8'hA5, m_ready=1 -> grant=4'b0100 one cycle later, m_data=8'hA5 with s_ready[2]=1 for one cycle, then IDLE one cycle, ptr=3.
- Fairness, burst off: s_valid=4'b1111 held, m_ready=1 -> grant sequence 0001, 0010, 0100, 1000, 0001 with one idle cycle between each; exactly one beat per grant.
- Burst on, MAX_BURST=4: requester 1 valid for 6 words, requester 3 valid -> requester 1 gets 4 beats, then requester 3 one grant, then requester 1 remaining 2.
- Backpressure: grant to requester 0, m_ready=0 for 5 cycles -> m_valid=1, m_data stable, s_ready=0, no release; m_ready=1 -> single beat accepted.
- Withdraw and reset mid-grant: granted requester drops s_valid -> IDLE next edge, ptr advances; separately, assert rst during GRANT -> grant=0 and busy=0 without waiting for clk.

Source files
------------

// File: rtl/vr_rr_arbiter.sv
// Round-robin N:1 valid/ready arbiter with a registered one-hot grant.
// Optional feature macro: ARB_BURST_EN (up to MAX_BURST beats per grant).

module vr_rr_lane #(
  parameter int L = 8
) (
  input  logic         gnt,
  input  logic         s_valid,
  input  logic         m_ready,
  input  logic [L-1:0] s_data,
  output logic         s_ready,
  output logic         vld,
  output logic [L-1:0] data
);
  assign s_ready = gnt & m_ready;
  assign vld     = gnt & s_valid;
  assign data    = gnt ? s_data : '0;
endmodule

module vr_rr_arbiter #(
  parameter int L         = 8,
  parameter int N         = 4,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   s_valid,
  input  logic [N*L-1:0] s_data,
  output logic [N-1:0]   s_ready,
  output logic           m_valid,
  output logic [L-1:0]   m_data,
  input  logic           m_ready,
  output logic [N-1:0]   grant,
  output logic           busy
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
`ifdef ARB_BURST_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif
  localparam int         BURST_LEN = BURST_ON ? MAX_BURST : 1;
  localparam logic [3:0] LAST_CNT  = 4'(BURST_LEN - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e               state_q, state_d;
  logic [N-1:0]         grant_q, grant_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [3:0]           beat_cnt_q, beat_cnt_d;
  logic [PW-1:0]        g_idx, idx;
  logic [N-1:0]         sel_oh, lane_vld;
  logic [N-1:0][L-1:0]  lane_data;
  logic                 found, g_valid, beat;

  for (genvar i = 0; i < N; i++) begin : g_lane
    vr_rr_lane #(.L(L)) u_lane (
      .gnt     (grant_q[i]),
      .s_valid (s_valid[i]),
      .m_ready (m_ready),
      .s_data  (s_data[i*L +: L]),
      .s_ready (s_ready[i]),
      .vld     (lane_vld[i]),
      .data    (lane_data[i])
    );
  end

  // Lanes are zero unless granted, so an OR-reduce is the output mux.
  always_comb begin
    m_data = '0;
    for (int i = 0; i < N; i++) m_data = m_data | lane_data[i];
  end

  assign g_valid = |lane_vld;
  assign m_valid = g_valid;
  assign busy    = (state_q == GRANT);
  assign grant   = grant_q;
  assign beat    = busy & g_valid & m_ready;

  // Scan starting at ptr; the last-served requester sits at the end.
  always_comb begin
    sel_oh = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_q) + i) % N);
      if (!found && s_valid[idx]) begin
        found       = 1'b1;
        sel_oh[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < N; i++)
      if (grant_q[i]) g_idx = PW'(i);
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: if (found) begin
        state_d    = GRANT;
        grant_d    = sel_oh;
        beat_cnt_d = '0;
      end
      GRANT: begin
        if (!g_valid || (beat && beat_cnt_q == LAST_CNT)) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (g_idx == PW'(N-1)) ? '0 : g_idx + PW'(1);
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule

// File: tb/tb_vr_rr_arbiter.sv
// Directed bench for vr_rr_arbiter; a small requester model pops words on handshakes.
module tb_vr_rr_arbiter;
  localparam int L = 8, N = 4, MB = 4;
`ifdef ARB_BURST_EN
  localparam int BB = MB;
  localparam int BLEN = 12;
  localparam logic [3:0] BSEQ [BLEN] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1000,
                                         4'b1000, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
`else
  localparam int BB = 1;
  localparam int BLEN = 14;
  localparam logic [3:0] BSEQ [BLEN] = '{4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0010, 4'b0000, 4'b0010,
                                         4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000};
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   s_valid = '0;
  logic [N*L-1:0] s_data = '0;
  logic [N-1:0]   s_ready;
  logic           m_valid;
  logic [L-1:0]   m_data;
  logic           m_ready = 1'b0;
  logic [N-1:0]   grant;
  logic           busy;

  int errs = 0, checks = 0;
  int rem [N] = '{default: 0};
  int beats [N] = '{default: 0};
  logic [L-1:0] nxt [N] = '{default: '0};
  logic [N-1:0] hs = '0;

  always #5 clk = ~clk;

  vr_rr_arbiter #(.L(L), .N(N), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .grant(grant), .busy(busy)
  );

  // Requester model: handshake sampled just before the edge, next word presented after it.
  always @(negedge clk) begin
    #3;
    hs = s_valid & s_ready;
  end
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++)
      if (hs[i]) begin
        beats[i]++;
        rem[i]--;
        nxt[i] = nxt[i] + 8'd1;
        s_valid[i] = (rem[i] > 0);
        s_data[i*L +: L] = nxt[i];
      end
  end

  task automatic load(input int i, input int n, input logic [L-1:0] b);
    rem[i] = n;
    nxt[i] = b;
    s_valid[i] = (n > 0);
    s_data[i*L +: L] = b;
  endtask

  task automatic do_reset;
    @(negedge clk);
    #1 rst = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      load(i, 0, '0);
      beats[i] = 0;
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    logic [17:0] act;
    rst = 1'b0;
    s_valid = '1;
    s_data = {N{8'hEE}};
    m_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 0) #1; else @(negedge clk);
      act = {busy, grant, s_ready, m_valid, m_data};
      checks++;
      if (act !== 18'h0) begin
        errs++;
        $display("FAIL reset_outputs cyc%0d: got %h want 0", c, act);
      end
    end
    s_valid = '0;
  endtask

  task automatic test_single;
    logic [17:0] act;
    do_reset();
    m_ready = 1'b1;
    load(2, 1, 8'hA5);
    @(negedge clk);
    act = {busy, grant, s_ready, m_valid, m_data};
    checks++;
    if (act !== {1'b1, 4'b0100, 4'b0100, 1'b1, 8'hA5}) begin
      errs++;
      $display("FAIL single_grant: got %h want %h", act, {1'b1, 4'b0100, 4'b0100, 1'b1, 8'hA5});
    end
    repeat (BB > 1 ? 2 : 1) @(negedge clk);
    act = {busy, grant, s_ready, m_valid, 8'h00};
    checks++;
    if (act !== 18'h0) begin
      errs++;
      $display("FAIL single_release_idle: got %h want 0", act);
    end
    load(2, 1, 8'h22);
    load(3, 1, 8'h33);
    @(negedge clk);
    checks++;
    if ({grant, m_data} !== {4'b1000, 8'h33}) begin
      errs++;
      $display("FAIL single_ptr_next: got %h want %h", {grant, m_data}, {4'b1000, 8'h33});
    end
    repeat (BB > 1 ? 3 : 2) @(negedge clk);
    checks++;
    if ({grant, m_data} !== {4'b0100, 8'h22}) begin
      errs++;
      $display("FAIL single_ptr_wrap: got %h want %h", {grant, m_data}, {4'b0100, 8'h22});
    end
  endtask

  task automatic test_fairness;
    logic [3:0] eg;
    logic [L-1:0] ed;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < N; i++) load(i, 100, 8'(8'h10 * (i + 1)));
    for (int k = 0; k < 5; k++) begin
      eg = 4'b0001 << (k % 4);
      for (int b = 0; b < BB; b++) begin
        @(negedge clk);
        ed = 8'(8'h10 * ((k % 4) + 1) + (k / 4) * BB + b);
        checks++;
        if ({grant, s_ready, m_valid, m_data} !== {eg, eg, 1'b1, ed}) begin
          errs++;
          $display("FAIL fair_grant k%0d b%0d: got %h want %h", k, b,
                   {grant, s_ready, m_valid, m_data}, {eg, eg, 1'b1, ed});
        end
      end
      @(negedge clk);
      checks++;
      if ({busy, grant} !== 5'b0) begin
        errs++;
        $display("FAIL fair_idle k%0d: got %h want 0", k, {busy, grant});
      end
    end
    checks++;
    if ({beats[0], beats[1], beats[2], beats[3]} !== {2 * BB, BB, BB, BB}) begin
      errs++;
      $display("FAIL fair_beats: got %0d %0d %0d %0d want %0d %0d %0d %0d",
               beats[0], beats[1], beats[2], beats[3], 2 * BB, BB, BB, BB);
    end
  endtask

  task automatic test_burst;
    do_reset();
    m_ready = 1'b1;
    load(1, 6, 8'hB0);
    load(3, 1, 8'hC0);
    for (int c = 0; c < BLEN; c++) begin
      @(negedge clk);
      checks++;
      if (grant !== BSEQ[c]) begin
        errs++;
        $display("FAIL burst_seq c%0d: got %b want %b", c, grant, BSEQ[c]);
      end
    end
    checks++;
    if ({beats[1], beats[3]} !== {32'd6, 32'd1}) begin
      errs++;
      $display("FAIL burst_beats: got %0d %0d want 6 1", beats[1], beats[3]);
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    load(0, 1, 8'h5C);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({busy, grant, s_ready, m_valid, m_data} !== {1'b1, 4'b0001, 4'b0000, 1'b1, 8'h5C}) begin
        errs++;
        $display("FAIL bp_hold c%0d: got %h want %h", c, {busy, grant, s_ready, m_valid, m_data},
                 {1'b1, 4'b0001, 4'b0000, 1'b1, 8'h5C});
      end
    end
    #1 m_ready = 1'b1;
    #1;
    checks++;
    if ({s_ready, m_valid} !== {4'b0001, 1'b1}) begin
      errs++;
      $display("FAIL bp_ready: got %h want %h", {s_ready, m_valid}, {4'b0001, 1'b1});
    end
    repeat (BB > 1 ? 2 : 1) @(negedge clk);
    checks++;
    if ({busy, grant, beats[0]} !== {1'b0, 4'b0000, 32'd1}) begin
      errs++;
      $display("FAIL bp_single_beat: busy=%b grant=%b beats=%0d want 0 0000 1", busy, grant, beats[0]);
    end
  endtask

  task automatic test_withdraw;
    logic [17:0] act;
    do_reset();
    load(1, 1, 8'h77);
    @(negedge clk);
    #1 load(1, 0, 8'h77);
    #1;
    checks++;
    if ({busy, grant, m_valid} !== {1'b1, 4'b0010, 1'b0}) begin
      errs++;
      $display("FAIL wd_drop: got %h want %h", {busy, grant, m_valid}, {1'b1, 4'b0010, 1'b0});
    end
    @(negedge clk);
    checks++;
    if ({busy, grant} !== 5'b0) begin
      errs++;
      $display("FAIL wd_release: got %h want 0", {busy, grant});
    end
    load(1, 1, 8'h77);
    load(2, 1, 8'h88);
    @(negedge clk);
    checks++;
    if ({grant, m_data} !== {4'b0100, 8'h88}) begin
      errs++;
      $display("FAIL wd_ptr_advance: got %h want %h", {grant, m_data}, {4'b0100, 8'h88});
    end
    #2 rst = 1'b0;
    #1;
    act = {busy, grant, s_ready, m_valid, m_data};
    checks++;
    if (act !== 18'h0) begin
      errs++;
      $display("FAIL async_reset_mid_grant: got %h want 0", act);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_burst();
    test_backpressure();
    test_withdraw();
    do_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
